full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameters: none; all data ports SHALL be fixed at 1 bit.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 A  input  1  addend bit A.
REQ-005 B  input  1  addend bit B.
REQ-006 carry_in  input  1  carry into this bit position.
REQ-007 sum  output  1  registered sum bit.
REQ-008 carry_out  output  1  registered carry out of this bit position.
REQ-009 out_valid  output  1  high when sum/carry_out hold a result computed from sampled inputs since the last reset.

Function
REQ-010 The block SHALL compute the 2-bit total T = A + B + carry_in with no truncation; {carry_out, sum} = T.
REQ-011 sum SHALL equal A XOR B XOR carry_in.
REQ-012 carry_out SHALL equal (A AND B) OR (A AND carry_in) OR (B AND carry_in).
REQ-013 Inputs SHALL be sampled on every rising clk edge with rst_n high; results SHALL appear on sum/carry_out after that edge (latency 1 cycle).
REQ-014 Outputs SHALL hold their value between edges; input changes between edges SHALL NOT affect outputs until the next edge.
REQ-015 There is no handshake and no back-pressure; a new operation SHALL be accepted every cycle (throughput 1 per cycle).
REQ-016 out_valid SHALL go high on the first rising edge with rst_n high and SHALL remain high until the next reset.
REQ-017 X/Z on any data input SHALL NOT be resolved by the block; it SHALL propagate per standard RTL operator semantics (no masking logic).
REQ-018 Full truth table the block SHALL implement (A B carry_in -> carry_out sum): 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
REQ-019 The core SHALL be symmetric: any permutation of A, B, carry_in SHALL yield identical outputs.

Reset
REQ-020 On a rising clk edge with rst_n low: sum=0, carry_out=0, out_valid=0; inputs on that edge SHALL be ignored.
REQ-021 Reset SHALL be purely synchronous: asserting rst_n low between edges SHALL NOT change outputs until the next rising edge.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result; the first edge after release SHALL produce a result from the inputs present at that edge.
REQ-023 Power-up before the first reset edge SHALL be treated as undefined; the bench SHALL NOT check outputs before it.

Verification
REQ-024 Exhaustive sweep: drive {A,B,carry_in}=000..111 one per cycle after reset -> the outputs one cycle later match REQ-018 (e.g. 111 -> carry_out=1, sum=1), with out_valid=1.
REQ-025 Reset values: hold rst_n=0 with A=B=carry_in=1 for 2 edges -> sum=0, carry_out=0, out_valid=0.
REQ-026 Latency: at edge N apply 000, at edge N+1 apply 110 -> after edge N sum/carry_out=0/0; after edge N+1 sum=0, carry_out=1.
REQ-027 Mid-edge glitch: toggle A between edges and restore it before the next edge -> outputs unchanged.
REQ-028 Mid-stream reset: apply 011, pull rst_n low for 1 edge, then release with 100 -> 0/0 with out_valid=0 during reset, then sum=1, carry_out=0 with out_valid=1.
REQ-029 Async check: drop rst_n between edges -> outputs and out_valid unchanged until the next rising edge.

Source files
------------

// File: rtl/full_adder.sv
// Registered one-bit full adder: inputs are sampled on each rising edge and
// {carry_out, sum} appear one cycle later, with out_valid marking live results.
module full_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic carry_in,
    output logic sum,
    output logic carry_out,
    output logic out_valid
);

    logic sum_next;
    logic carry_next;
    logic sum_reg;
    logic carry_reg;
    logic valid_reg;

    // Plain operators with no masking, so X/Z on an input propagates as written.
    assign sum_next   = A ^ B ^ carry_in;
    assign carry_next = (A & B) | (A & carry_in) | (B & carry_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg   <= 1'b0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            valid_reg <= 1'b1;
        end
    end

    assign sum       = sum_reg;
    assign carry_out = carry_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: truth-table vectors plus hand-written
// sequences for reset, latency, mid-cycle glitches and mid-stream reset.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic A;
    logic B;
    logic carry_in;
    logic sum;
    logic carry_out;
    logic out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic exp_co;
        logic exp_s;
    } vec_t;

    vec_t vecs[8];

    full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Compares {out_valid, carry_out, sum} against the expected triple.
    task automatic check(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {out_valid, carry_out, sum};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid/co/s=%b required %b", name, act, exp);
        end else begin
            $display("ok   %s: valid/co/s=%b", name, act);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic c);
        rst_n    = r;
        A        = a;
        B        = b;
        carry_in = c;
    endtask

    task automatic edge_tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset held with all inputs high: inputs must be ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        edge_tick();
        check("reset_edge1", 3'b000);
        edge_tick();
        check("reset_edge2", 3'b000);

        // Exhaustive sweep, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            edge_tick();
            check($sformatf("sweep_%0d%0d%0d", vecs[i].a, vecs[i].b, vecs[i].c),
                  {1'b1, vecs[i].exp_co, vecs[i].exp_s});
        end

        // Latency: 000 then 110 on consecutive edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        edge_tick();
        check("latency_000", 3'b100);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        edge_tick();
        check("latency_110", 3'b110);

        // Glitch on A between edges, restored before the next edge.
        #2 A = 1'b0;
        #1 check("glitch_midcycle", 3'b110);
        #1 A = 1'b1;
        edge_tick();
        check("glitch_next_edge", 3'b110);

        // Mid-stream reset discards the in-flight result.
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        edge_tick();
        check("midrst_011", 3'b110);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        edge_tick();
        check("midrst_in_reset", 3'b000);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        edge_tick();
        check("midrst_release_100", 3'b101);

        // Reset dropped between edges must wait for the next rising edge.
        #2 rst_n = 1'b0;
        #1 check("async_rst_midcycle", 3'b101);
        edge_tick();
        check("async_rst_edge", 3'b000);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        edge_tick();
        check("async_release_111", 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
